// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with PC-tagged in-order queue
//
// Issues sequential word fetches over a req/gnt + rvalid bus, buffers returned
// instructions with their PC in a DEPTH-entry queue, and presents the head to
// decode on a valid/ready handshake. A redirect flushes the queue and arranges
// for in-flight wrong-path responses to be discarded.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   redirect_i, redirect_pc_i taken branch/jump and its target
//   imem_req_o, imem_addr_o   fetch request and word-aligned address
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i, imem_rdata_i in-order response
//   inst_valid_o, inst_o, pc_o, pc4_o  queue head to decode
//   inst_ready_i              decode accepts the head

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  input  logic        inst_ready_i
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [DEPTH-1:0] fil_q;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc4_q  [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q, fill_q;
  logic [CW-1:0]    occ_q;   // reserved entries
  logic [CW-1:0]    pend_q;  // reserved but not yet filled
  logic [7:0]       drop_q;  // wrong-path responses still to be discarded
  logic [31:0]      fetch_pc_q;

  logic       grant, pop, drop, fill;
  logic [8:0] drop_sum, drop_nx;

  // Gating with rst keeps the request low while reset is held, independent of clocking.
  assign imem_req_o  = rst & ~redirect_i & (occ_q < CW'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o & imem_gnt_i;

  assign inst_valid_o = fil_q[head_q] & ~redirect_i;
  assign inst_o       = inst_q[head_q];
  assign pc_o         = pc_q[head_q];
  // PC+4 is stored per entry so the head outputs come purely from registers.
  assign pc4_o        = pc4_q[head_q];
  assign pop          = inst_valid_o & inst_ready_i;

  assign drop = imem_rvalid_i & (drop_q != 8'd0);
  assign fill = imem_rvalid_i & (drop_q == 8'd0) & (pend_q != '0);

  // On redirect every unfilled reservation becomes a response to throw away;
  // a response arriving in the redirect cycle itself is consumed from that count.
  assign drop_sum = {1'b0, drop_q} + 9'(pend_q);
  assign drop_nx  = (imem_rvalid_i && drop_sum != 9'd0) ? drop_sum - 9'd1 : drop_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fil_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pc4_q[i]  <= '0;
        inst_q[i] <= NOP;
      end
    end else if (redirect_i) begin
      fil_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      pend_q     <= '0;
      drop_q     <= drop_nx[7:0];
      fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (grant) begin
        pc_q[tail_q]  <= fetch_pc_q;
        pc4_q[tail_q] <= fetch_pc_q + 32'd4;
        fetch_pc_q    <= fetch_pc_q + 32'd4;
        tail_q        <= tail_q + 1'b1;
      end
      if (drop) begin
        drop_q <= drop_q - 8'd1;
      end
      // The fill target is never the popped head: a pop needs a filled head.
      if (fill) begin
        fil_q[fill_q]  <= 1'b1;
        inst_q[fill_q] <= imem_rdata_i;
        fill_q         <= fill_q + 1'b1;
      end
      if (pop) begin
        fil_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      occ_q  <= occ_q + CW'(grant) - CW'(pop);
      pend_q <= pend_q + CW'(grant) - CW'(fill);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        inst_ready_i;

  int          total = 0;
  int          bad   = 0;
  bit          auto_rsp;
  logic [31:0] pq[$];
  int          grants;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .inst_ready_i  (inst_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: record a grant seen before the edge, then drive this cycle's response.
  // Memory contents are 32'hC000_0000 + address.
  task automatic tick();
    logic        f;
    logic [31:0] a;
    f = imem_req_o & imem_gnt_i;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    if (f) pq.push_back(a);
    imem_rvalid_i = 1'b0;
    if (auto_rsp && pq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hC000_0000 + pq.pop_front();
    end
    #1;
  endtask

  task automatic rsp();
    if (pq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hC000_0000 + pq.pop_front();
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    inst_ready_i  = 1'b0;
    auto_rsp      = 1'b0;
    pq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc4_o, 32'h0);

    // gnt held low: request and address hold, nothing becomes valid
    inst_ready_i = 1'b1;
    release_rst();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'h0, imem_req_o}, 32'h1);
      chk("stall_addr", imem_addr_o, 32'h0);
      chk("stall_valid", {31'h0, inst_valid_o}, 32'h0);
      tick();
    end
    imem_gnt_i = 1'b1;
    #1;
    chk("stall_addr_end", imem_addr_o, 32'h0);
    tick();
    chk("stall_addr_next", imem_addr_o, 32'h4);

    // streaming fetch, 1-cycle memory
    do_reset();
    imem_gnt_i   = 1'b1;
    inst_ready_i = 1'b1;
    auto_rsp     = 1'b1;
    release_rst();
    chk("s_c0_addr", imem_addr_o, 32'h0);
    chk("s_c0_req", {31'h0, imem_req_o}, 32'h1);
    chk("s_c0_valid", {31'h0, inst_valid_o}, 32'h0);
    tick();
    chk("s_c1_addr", imem_addr_o, 32'h4);
    chk("s_c1_valid", {31'h0, inst_valid_o}, 32'h0);
    tick();
    chk("s_c2_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("s_c2_pc", pc_o, 32'h0);
    chk("s_c2_inst", inst_o, 32'hC000_0000);
    chk("s_c2_pc4", pc4_o, 32'h4);
    chk("s_c2_addr", imem_addr_o, 32'h8);
    tick();
    chk("s_c3_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("s_c3_pc", pc_o, 32'h4);
    chk("s_c3_inst", inst_o, 32'hC000_0004);
    tick();
    chk("s_c4_pc", pc_o, 32'h8);
    chk("s_c4_inst", inst_o, 32'hC000_0008);
    chk("s_c4_pc4", pc4_o, 32'hC);

    // decode stall fills the queue, then drains in order
    do_reset();
    imem_gnt_i = 1'b1;
    auto_rsp   = 1'b1;
    release_rst();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_o && imem_gnt_i) grants++;
      tick();
    end
    chk("full_grants", grants, 32'd4);
    chk("full_req", {31'h0, imem_req_o}, 32'h0);
    inst_ready_i = 1'b1;
    #1;
    chk("drain0_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("drain0_pc", pc_o, 32'h0);
    chk("drain0_req", {31'h0, imem_req_o}, 32'h0);
    tick();
    chk("drain1_req", {31'h0, imem_req_o}, 32'h1);
    chk("drain1_pc", pc_o, 32'h4);
    tick();
    chk("drain2_pc", pc_o, 32'h8);
    chk("drain2_inst", inst_o, 32'hC000_0008);
    tick();
    chk("drain3_pc", pc_o, 32'hC);
    chk("drain3_inst", inst_o, 32'hC000_000C);
    chk("drain3_valid", {31'h0, inst_valid_o}, 32'h1);

    // redirect with two fetches outstanding
    do_reset();
    imem_gnt_i   = 1'b1;
    inst_ready_i = 1'b1;
    release_rst();
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    #1;
    chk("rd_req_low", {31'h0, imem_req_o}, 32'h0);
    chk("rd_valid_low", {31'h0, inst_valid_o}, 32'h0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rd_req", {31'h0, imem_req_o}, 32'h1);
    chk("rd_addr", imem_addr_o, 32'h100);
    rsp();
    tick();
    rsp();
    #1;
    chk("rd_drop1_valid", {31'h0, inst_valid_o}, 32'h0);
    tick();
    rsp();
    #1;
    chk("rd_drop2_valid", {31'h0, inst_valid_o}, 32'h0);
    tick();
    chk("rd_tgt_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("rd_tgt_pc", pc_o, 32'h100);
    chk("rd_tgt_inst", inst_o, 32'hC000_0100);
    chk("rd_tgt_pc4", pc4_o, 32'h104);

    // redirect coincident with rvalid and a valid head
    do_reset();
    imem_gnt_i = 1'b1;
    release_rst();
    tick();
    rsp();
    tick();
    tick();
    chk("rc_head_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("rc_head_pc", pc_o, 32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    inst_ready_i  = 1'b1;
    rsp();
    #1;
    chk("rc_valid_low", {31'h0, inst_valid_o}, 32'h0);
    chk("rc_req_low", {31'h0, imem_req_o}, 32'h0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rc_addr", imem_addr_o, 32'h200);
    chk("rc_valid_c4", {31'h0, inst_valid_o}, 32'h0);
    rsp();
    tick();
    rsp();
    #1;
    chk("rc_valid_c5", {31'h0, inst_valid_o}, 32'h0);
    tick();
    chk("rc_tgt_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("rc_tgt_pc", pc_o, 32'h200);
    chk("rc_tgt_inst", inst_o, 32'hC000_0200);

    // asynchronous reset with queue full and two drops pending
    do_reset();
    imem_gnt_i = 1'b1;
    release_rst();
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) tick();
    chk("ar_full_req", {31'h0, imem_req_o}, 32'h0);
    chk("ar_pre_addr", imem_addr_o, 32'h310);
    chk("ar_pre_pc", pc_o, 32'h300);
    chk("ar_pre_pc4", pc4_o, 32'h304);
    rst = 1'b0;
    #1;
    chk("ar_req", {31'h0, imem_req_o}, 32'h0);
    chk("ar_addr", imem_addr_o, 32'h0);
    chk("ar_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("ar_inst", inst_o, 32'h0000_0013);
    chk("ar_pc", pc_o, 32'h0);
    chk("ar_pc4", pc4_o, 32'h0);
    @(posedge clk);
    #1;
    pq.delete();
    auto_rsp     = 1'b1;
    inst_ready_i = 1'b1;
    release_rst();
    chk("ar_rel_addr", imem_addr_o, 32'h0);
    chk("ar_rel_req", {31'h0, imem_req_o}, 32'h1);
    tick();
    tick();
    chk("ar_rel_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("ar_rel_pc", pc_o, 32'h0);
    chk("ar_rel_inst", inst_o, 32'hC000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
